// File: rtl/nvp_v1_quant_act_pool.sv
// Quantize, activate and optionally max-pool a stream of wide signed accumulator values.
// Two-stage pipeline with a single global enable for valid/ready backpressure.
module nvp_v1_quant_act_pool #(
    parameter int unsigned           DATA_WIDTH        = 16,
    parameter int unsigned           FRAC_SHIFT        = 8,
    parameter int unsigned           UNQUANTIZED_WIDTH = 48,
    parameter int unsigned           POOL_COUNT_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] CLAMP_VALUE       = 16'h0600
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   cfg_activation,
    input  logic                         cfg_pooling,
    input  logic [POOL_COUNT_WIDTH-1:0]  cfg_pool_count,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [UNQUANTIZED_WIDTH-1:0] s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic                         sat_flag,
    input  logic                         clr_sat
);

    localparam int unsigned DW  = DATA_WIDTH;
    localparam int unsigned UW  = UNQUANTIZED_WIDTH;
    localparam int unsigned PCW = POOL_COUNT_WIDTH;
    localparam logic [DW-1:0] Q_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};

    logic                 en;
    logic signed [UW-1:0] shifted;
    logic                 overflow;
    logic [DW-1:0]        quant;

    logic                 q1_valid;
    logic [DW-1:0]        q1_data;
    logic [PCW-1:0]       win_cnt;
    logic [DW-1:0]        max_q;
    logic [1:0]           act_q;
    logic                 pool_q;
    logic [PCW-1:0]       pcnt_q;

    logic                 win_start;
    logic [1:0]           act_mode;
    logic                 pool_mode;
    logic [PCW-1:0]       pool_n;
    logic [PCW-1:0]       n_eff;
    logic                 pool_on;
    logic                 win_last;
    logic [DW-1:0]        relu;
    logic [DW-1:0]        act;
    logic [DW-1:0]        max_upd;

    logic                 m_valid_d;
    logic [DW-1:0]        m_data_d;
    logic [PCW-1:0]       win_cnt_d;
    logic [DW-1:0]        max_d;
    logic [1:0]           act_d;
    logic                 pool_d;
    logic [PCW-1:0]       pcnt_d;
    logic                 sat_d;

    assign en      = !m_valid || m_ready;
    assign s_ready = en;

    // Quantizer: arithmetic shift, then saturate if the dropped high bits are not a sign extension
    assign shifted  = $signed(s_data) >>> FRAC_SHIFT;
    assign overflow = (shifted[UW-1:DW-1] != {(UW-DW+1){shifted[UW-1]}});
    assign quant    = overflow ? (shifted[UW-1] ? Q_MIN : Q_MAX) : shifted[DW-1:0];

    // The window's first element sees live config; later elements use the copy latched with it
    assign win_start = (win_cnt == '0);
    assign act_mode  = win_start ? cfg_activation : act_q;
    assign pool_mode = win_start ? cfg_pooling    : pool_q;
    assign pool_n    = win_start ? cfg_pool_count : pcnt_q;
    assign n_eff     = (pool_n == '0) ? PCW'(1) : pool_n;
    assign pool_on   = pool_mode && (n_eff != PCW'(1));
    assign win_last  = (win_cnt == (n_eff - PCW'(1)));

    always_comb begin
        relu = q1_data;
        if ((act_mode == 2'd1 || act_mode == 2'd2) && q1_data[DW-1]) begin
            relu = '0;
        end
    end

    always_comb begin
        act = relu;
        if (act_mode == 2'd2 && $signed(relu) > $signed(CLAMP_VALUE)) begin
            act = CLAMP_VALUE;
        end
    end

    assign max_upd = (win_start || ($signed(act) > $signed(max_q))) ? act : max_q;

    // Stage-2 / pooling next-state
    always_comb begin
        m_valid_d = m_valid;
        m_data_d  = m_data;
        win_cnt_d = win_cnt;
        max_d     = max_q;
        act_d     = act_q;
        pool_d    = pool_q;
        pcnt_d    = pcnt_q;
        if (en) begin
            m_valid_d = 1'b0;
            if (q1_valid) begin
                if (win_start) begin
                    act_d  = cfg_activation;
                    pool_d = cfg_pooling;
                    pcnt_d = cfg_pool_count;
                end
                if (!pool_on) begin
                    m_valid_d = 1'b1;
                    m_data_d  = act;
                    win_cnt_d = '0;
                end else if (win_last) begin
                    m_valid_d = 1'b1;
                    m_data_d  = max_upd;
                    win_cnt_d = '0;
                end else begin
                    max_d     = max_upd;
                    win_cnt_d = win_cnt + PCW'(1);
                end
            end
        end
    end

    // Sticky saturation: a new saturating accept wins over a clear in the same cycle
    always_comb begin
        sat_d = sat_flag;
        if (en && s_valid && overflow) begin
            sat_d = 1'b1;
        end else if (clr_sat) begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q1_valid <= 1'b0;
            q1_data  <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            win_cnt  <= '0;
            max_q    <= '0;
            act_q    <= '0;
            pool_q   <= 1'b0;
            pcnt_q   <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (en) begin
                q1_valid <= s_valid;
                q1_data  <= quant;
            end
            m_valid  <= m_valid_d;
            m_data   <= m_data_d;
            win_cnt  <= win_cnt_d;
            max_q    <= max_d;
            act_q    <= act_d;
            pool_q   <= pool_d;
            pcnt_q   <= pcnt_d;
            sat_flag <= sat_d;
        end
    end

endmodule

// File: tb/tb_nvp_v1_quant_act_pool.sv
// Directed and randomized checks of nvp_v1_quant_act_pool against a window-queue reference model.
module tb_nvp_v1_quant_act_pool;

    logic        clk;
    logic        rst;
    logic [1:0]  cfg_activation;
    logic        cfg_pooling;
    logic [3:0]  cfg_pool_count;
    logic        s_valid;
    logic        s_ready;
    logic [47:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        sat_flag;
    logic        clr_sat;

    nvp_v1_quant_act_pool dut (
        .clk(clk), .rst(rst),
        .cfg_activation(cfg_activation), .cfg_pooling(cfg_pooling), .cfg_pool_count(cfg_pool_count),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .sat_flag(sat_flag), .clr_sat(clr_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          n_out = 0;
    int          n0;
    logic        acc;
    logic        out;
    logic [47:0] acc_data;
    logic [15:0] out_data;
    logic [15:0] last_out;
    logic [15:0] held;

    // Reference model state: expected outputs and the elements of the open window
    logic [15:0] exp_q[$];
    logic [15:0] win_q[$];
    int          win_n;
    logic [1:0]  win_act;
    logic        model_sat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model_quant(input logic [47:0] d);
        longint v;
        v = longint'($signed(d)) >>> 8;
        if (v > 32767)  return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(v)};
    endfunction

    function automatic logic [15:0] model_act(input logic [15:0] q, input logic [1:0] mode);
        int v;
        v = int'($signed(q));
        if ((mode == 2'd1 || mode == 2'd2) && v < 0) v = 0;
        if (mode == 2'd2 && v > 1536) v = 1536;
        return 16'(v);
    endfunction

    task automatic model_accept(input logic [47:0] d);
        logic [16:0] qs;
        logic [15:0] m;
        qs = model_quant(d);
        if (qs[16]) model_sat = 1'b1;
        if (win_q.size() == 0) begin
            win_act = cfg_activation;
            win_n   = (cfg_pool_count == 4'd0 || !cfg_pooling) ? 1 : int'(cfg_pool_count);
        end
        win_q.push_back(model_act(qs[15:0], win_act));
        if (win_q.size() == win_n) begin
            m = win_q[0];
            foreach (win_q[i]) if ($signed(win_q[i]) > $signed(m)) m = win_q[i];
            exp_q.push_back(m);
            win_q.delete();
        end
    endtask

    // One clock: sample handshakes away from the edge, update model and scoreboard at the edge
    task automatic cycle();
        logic [15:0] e;
        #1;
        acc      = s_valid && s_ready && !rst;
        acc_data = s_data;
        out      = m_valid && m_ready && !rst;
        out_data = m_data;
        @(posedge clk);
        if (acc) model_accept(acc_data);
        if (out) begin
            n_out++;
            last_out = out_data;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL out_extra observed=%0h expected=none", out_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e));
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        repeat (n) cycle();
    endtask

    task automatic send(input logic [47:0] d);
        s_valid = 1'b1;
        s_data  = d;
        acc     = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) cycle();
        total++;
        assert (acc) else begin
            bad++;
            $error("FAIL send_timeout observed=%0b expected=1", acc);
        end
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        clr_sat = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        win_q.delete();
        exp_q.delete();
        model_sat = 1'b0;
    endtask

    function automatic logic [47:0] rand_data();
        logic [47:0] d;
        d = 48'({$urandom(), $urandom()});
        if ($urandom_range(0, 3) != 0) d = {{22{d[25]}}, d[25:0]};
        return d;
    endfunction

    initial begin
        rst = 1'b1; cfg_activation = 2'd0; cfg_pooling = 1'b0; cfg_pool_count = 4'd0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1; clr_sat = 1'b0;
        model_sat = 1'b0; win_n = 1; win_act = 2'd0; last_out = '0;
        @(negedge clk);
        do_reset();
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_data", 64'(m_data), 64'(0));
        chk("rst_sat", 64'(sat_flag), 64'(0));
        chk("rst_s_ready", 64'(s_ready), 64'(1));

        // Basic quantize and two-cycle latency
        send(48'h0000_0001_8000);
        chk("lat_early", 64'(m_valid), 64'(0));
        cycle();
        chk("lat_valid", 64'(m_valid), 64'(1));
        chk("lat_data", 64'(m_data), 64'(16'h0180));
        chk("lat_sat", 64'(sat_flag), 64'(0));
        drain(2);

        // Saturation and sticky flag
        send(48'h0000_0100_0000);
        chk("sat_set", 64'(sat_flag), 64'(1));
        drain(3);
        chk("sat_pos", 64'(last_out), 64'(16'h7FFF));
        send(48'h8000_0000_0000);
        drain(3);
        chk("sat_neg", 64'(last_out), 64'(16'h8000));
        clr_sat = 1'b1;
        cycle();
        clr_sat = 1'b0;
        chk("sat_clr", 64'(sat_flag), 64'(0));
        clr_sat = 1'b1;
        send(48'h0000_0100_0000);
        clr_sat = 1'b0;
        chk("sat_set_wins", 64'(sat_flag), 64'(1));
        drain(3);

        // Activation modes
        cfg_activation = 2'd1; send(48'hFFFF_FFFF_0000); drain(3);
        chk("relu_neg", 64'(last_out), 64'(16'h0000));
        cfg_activation = 2'd2; send(48'h0000_0008_0000); drain(3);
        chk("relu_clamp", 64'(last_out), 64'(16'h0600));
        cfg_activation = 2'd3; send(48'hFFFF_FFFF_0000); drain(3);
        chk("mode3_neg", 64'(last_out), 64'(16'hFF00));
        send(48'h0000_0008_0000); drain(3);
        chk("mode3_big", 64'(last_out), 64'(16'h0800));

        // Max pool N=4 with a mid-window config change
        cfg_activation = 2'd0; cfg_pooling = 1'b1; cfg_pool_count = 4'd4;
        n0 = n_out;
        send(48'h0000_0001_0000);
        cycle();
        cfg_pool_count = 4'd2;
        send(48'hFFFF_FFFF_0000);
        send(48'h0000_0003_0000);
        send(48'h0000_0002_0000);
        chk("pool_not_early", 64'(m_valid), 64'(0));
        chk("pool_no_out", 64'(n_out - n0), 64'(0));
        cycle();
        chk("pool_valid", 64'(m_valid), 64'(1));
        chk("pool_data", 64'(m_data), 64'(16'h0300));
        drain(3);
        chk("pool_one_out", 64'(n_out - n0), 64'(1));

        // Backpressure: hold for 5 cycles, nothing lost or duplicated
        cfg_pooling = 1'b0; cfg_pool_count = 4'd0;
        n0 = n_out;
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 48'h0000_0000_1100; cycle();
        s_data = 48'h0000_0000_2200; cycle();
        s_data = 48'h0000_0000_3300; cycle();
        held = m_data;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", 64'(m_valid), 64'(1));
            chk("bp_hold", 64'(m_data), 64'(held));
            chk("bp_s_ready", 64'(s_ready), 64'(0));
            cycle();
        end
        m_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) cycle();
        s_valid = 1'b0;
        drain(4);
        chk("bp_count", 64'(n_out - n0), 64'(3));
        chk("bp_empty", 64'(exp_q.size()), 64'(0));

        // Reset mid-window discards the partial window
        cfg_pooling = 1'b1; cfg_pool_count = 4'd4;
        send(48'h0000_0000_7000);
        send(48'h0000_0000_7100);
        do_reset();
        n0 = n_out;
        send(48'h0000_0000_1000);
        send(48'h0000_0000_2000);
        send(48'h0000_0000_3000);
        send(48'h0000_0000_4000);
        drain(4);
        chk("rstwin_count", 64'(n_out - n0), 64'(1));
        chk("rstwin_data", 64'(last_out), 64'(16'h0040));

        // Randomized phases with random valid/ready
        for (int ph = 0; ph < 8; ph++) begin
            cfg_activation = 2'($urandom_range(0, 3));
            cfg_pooling    = 1'($urandom_range(0, 1));
            cfg_pool_count = 4'($urandom_range(0, 5));
            for (int i = 0; i < 80; i++) begin
                if (!s_valid && $urandom_range(0, 9) < 7) begin
                    s_valid = 1'b1;
                    s_data  = rand_data();
                end
                m_ready = ($urandom_range(0, 3) != 0);
                cycle();
                if (acc) s_valid = 1'b0;
            end
            m_ready = 1'b1;
            for (int i = 0; i < 20 && s_valid; i++) begin
                cycle();
                if (acc) s_valid = 1'b0;
            end
            s_valid = 1'b0;
            drain(4);
            chk("rand_empty", 64'(exp_q.size()), 64'(0));
            chk("rand_sat", 64'(sat_flag), 64'(model_sat));
            do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
